// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - small register-file responder with self-clearing init sweep and access counters
module mem_responder #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              busy,
    output logic              uninit_rd,
    output logic              coll_err,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic              wr_go;
    logic              rd_go;

    assign wr_go = (state == READY) && wr_en;
    assign rd_go = (state == READY) && rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            INIT: begin
                busy = 1'b1;
                if (ptr == LAST) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Sweep pointer wraps back to 0 on the last entry, ready for the next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (state == INIT) begin
            ptr <= ptr + ADDR_W'(1);
        end
    end

    // Storage is cleared by the INIT sweep rather than by reset, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[ptr]     <= '0;
            written[ptr] <= 1'b0;
        end else if (wr_en) begin
            mem[addr]     <= wdata;
            written[addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata     <= '0;
            rd_valid  <= 1'b0;
            uninit_rd <= 1'b0;
            coll_err  <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            rd_valid  <= rd_go;
            uninit_rd <= rd_go && !written[addr];
            coll_err  <= rd_go && wr_go;
            if (rd_go) begin
                rdata <= mem[addr];
                if (rd_count != {CNT_W{1'b1}}) begin
                    rd_count <= rd_count + CNT_W'(1);
                end
            end
            if (wr_go && (wr_count != {CNT_W{1'b1}})) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with directed vectors
module tb_mem_responder;

    logic       clk;
    logic       reset;
    logic [2:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       busy;
    logic       uninit_rd;
    logic       coll_err;
    logic [7:0] wr_count;
    logic [7:0] rd_count;

    typedef struct packed {
        logic [7:0] data;
        logic       un;
        logic       coll;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .busy     (busy),
        .uninit_rd(uninit_rd),
        .coll_err (coll_err),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every rd_valid pulse is matched against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd_valid: got rdata %0h expected no read", rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", int'(rdata), int'(e.data));
                    check("uninit_rd", int'(uninit_rd), int'(e.un));
                    check("coll_err", int'(coll_err), int'(e.coll));
                end
            end else if (uninit_rd || coll_err) begin
                checks++;
                errors++;
                $display("FAIL stray_flag: got uninit %0b coll %0b expected 0 0", uninit_rd, coll_err);
            end
        end
    end

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [2:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_rd(input logic [2:0] a, input logic [7:0] exp_d, input logic exp_un);
        addr  = a;
        wr_en = 1'b0;
        rd_en = 1'b1;
        exp_q.push_back('{data: exp_d, un: exp_un, coll: 1'b0});
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic do_both(input logic [2:0] a, input logic [7:0] d,
                           input logic [7:0] exp_d, input logic exp_un);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        rd_en = 1'b1;
        exp_q.push_back('{data: exp_d, un: exp_un, coll: 1'b1});
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        addr  = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        #12;
        check("rst_rdata", int'(rdata), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_wr_count", int'(wr_count), 0);
        check("rst_rd_count", int'(rd_count), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_init(n);
        check("init_cycles", n, 8);
        check("ready_busy", int'(busy), 0);
        check("ready_rd_count", int'(rd_count), 0);

        do_wr(3'd3, 8'hA5);
        do_rd(3'd3, 8'hA5, 1'b0);
        check("wr_count_1", int'(wr_count), 1);
        check("rd_count_1", int'(rd_count), 1);
        idle();
        idle();
        check("rdata_hold", int'(rdata), 8'hA5);
        check("rd_valid_idle", int'(rd_valid), 0);

        do_rd(3'd5, 8'h00, 1'b1);
        do_wr(3'd2, 8'h11);
        do_both(3'd2, 8'h22, 8'h11, 1'b0);
        do_rd(3'd2, 8'h22, 1'b0);
        idle();
        check("wr_count_3", int'(wr_count), 3);
        check("rd_count_4", int'(rd_count), 4);

        // Back-to-back reads on consecutive cycles
        do_rd(3'd3, 8'hA5, 1'b0);
        do_rd(3'd2, 8'h22, 1'b0);
        do_rd(3'd5, 8'h00, 1'b1);
        do_both(3'd6, 8'h66, 8'h00, 1'b1);
        do_rd(3'd6, 8'h66, 1'b0);
        idle();

        for (int i = 0; i < 300; i++) begin
            do_wr(3'(i), 8'(i));
        end
        idle();
        check("wr_count_sat", int'(wr_count), 255);
        check("rd_count_9", int'(rd_count), 9);

        for (int i = 0; i < 5; i++) begin
            do_wr(3'(i), 8'hF0);
        end
        // Asynchronous reset mid-activity, with requests held through INIT
        addr  = 3'd4;
        wdata = 8'hEE;
        wr_en = 1'b1;
        rd_en = 1'b1;
        reset = 1'b1;
        #1;
        check("mid_rst_wr_count", int'(wr_count), 0);
        check("mid_rst_rd_count", int'(rd_count), 0);
        check("mid_rst_busy", int'(busy), 1);
        check("mid_rst_rd_valid", int'(rd_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_init(n);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("reinit_cycles", n, 8);
        check("init_wr_count", int'(wr_count), 0);
        check("init_rd_count", int'(rd_count), 0);
        for (int i = 0; i < 8; i++) begin
            do_rd(3'(i), 8'h00, 1'b1);
        end
        idle();
        idle();
        check("final_rd_count", int'(rd_count), 8);
        check("final_wr_count", int'(wr_count), 0);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 3, address width; depth = 2**ADDR_W entries.
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 Parameter CNT_W, default 8, width of the access counters.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 addr  input  ADDR_W  entry address for the current request.
REQ-007 wr_en  input  1  write request, sampled at posedge clk.
REQ-008 rd_en  input  1  read request, sampled at posedge clk.
REQ-009 wdata  input  DATA_W  write data, sampled with wr_en.
REQ-010 rdata  output  DATA_W  registered read data.
REQ-011 rd_valid  output  1  one-cycle pulse: rdata carries the result of a read.
REQ-012 busy  output  1  high while the block is in INIT and ignores requests.
REQ-013 uninit_rd  output  1  pulses with rd_valid when the entry read has not been written since reset.
REQ-014 coll_err  output  1  one-cycle pulse one cycle after a sampled wr_en and rd_en.
REQ-015 wr_count  output  CNT_W  accepted write count, saturating.
REQ-016 rd_count  output  CNT_W  accepted read count, saturating.

Function
REQ-017 The FSM SHALL have two states, INIT and READY, and SHALL enter INIT on reset.
REQ-018 INIT: an internal pointer steps 0..depth-1, one entry per cycle, zeroing data and clearing that entry's written flag; after the last entry it goes to READY (INIT lasts exactly depth cycles, 8 by default).
REQ-019 busy = 1 exactly while in INIT; wr_en/rd_en sampled in INIT are ignored, uncounted, and produce no rd_valid or coll_err.
REQ-020 READY, wr_en=1: mem[addr] <= wdata, written flag of addr set, wr_count increments.
REQ-021 READY, rd_en=1: on the next edge rdata <= mem[addr], rd_valid=1 for one cycle, rd_count increments; read latency is 1 cycle.
REQ-022 rdata SHALL hold its last value when no read completes; rd_valid is 0 otherwise.
REQ-023 uninit_rd = rd_valid AND the entry's written flag was 0 at sample time.
REQ-024 wr_en and rd_en together in READY: both are performed. A read to the same addr returns the OLD data (read-before-write). Both counters increment, and coll_err pulses with rd_valid.
REQ-025 Back-to-back reads on consecutive cycles SHALL give rd_valid on consecutive cycles with no bubble.
REQ-026 A write to addr followed by a read of addr on the next cycle SHALL return the new data.
REQ-027 Counters SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-028 addr is always in range; every address value maps to a valid entry.

Reset
REQ-029 Reset assertion at any time SHALL immediately give: rdata=0, rd_valid=0, uninit_rd=0, coll_err=0, wr_count=0, rd_count=0, busy=1, state=INIT, pointer=0.
REQ-030 A reset during INIT or READY SHALL restart INIT from entry 0; no partial operation completes.
REQ-031 After reset is released, busy SHALL drop after exactly depth rising edges, and the first request is accepted on the next edge.

Verification
REQ-032 Reset release, hold requests -> busy high 8 cycles then low; all outputs 0.
REQ-033 Write addr 3 = 0xA5, next cycle read addr 3 -> one cycle later rdata=0xA5, rd_valid=1, uninit_rd=0; wr_count=1, rd_count=1.
REQ-034 Read addr 5 never written -> rdata=0x00, rd_valid=1, uninit_rd=1.
REQ-035 With mem[2]=0x11, wr_en+rd_en addr 2, wdata 0x22 -> rdata=0x11, coll_err=1; next read of addr 2 returns 0x22.
REQ-036 300 writes -> wr_count stops at 255; reset mid-sequence -> counters 0, busy=1, and reading any entry after INIT gives 0 with uninit_rd=1.
REQ-037 Requests during INIT -> no rd_valid, counters unchanged, memory still zero.
